// File: rtl/cacheline_burst_adaptor_if.sv
// Line-side and burst-side signal bundle of the cacheline burst adaptor.
// The slave modport is the adaptor's view; master is the environment's view
// (cache/write buffer on the line side, memory model on the burst side).
interface cacheline_burst_adaptor_if #(
  parameter int BEAT_WIDTH = 64,
  parameter int LINE_WIDTH = 256
);
  logic                  line_read;
  logic                  line_write;
  logic [31:0]           line_address;
  logic [LINE_WIDTH-1:0] line_wdata;
  logic [LINE_WIDTH-1:0] line_rdata;
  logic                  line_resp;
  logic                  burst_read;
  logic                  burst_write;
  logic [31:0]           burst_address;
  logic [BEAT_WIDTH-1:0] burst_wdata;
  logic [BEAT_WIDTH-1:0] burst_rdata;
  logic                  burst_resp;

  modport slave (
    input  line_read, line_write, line_address, line_wdata,
    input  burst_rdata, burst_resp,
    output line_rdata, line_resp,
    output burst_read, burst_write, burst_address, burst_wdata
  );

  modport master (
    output line_read, line_write, line_address, line_wdata,
    output burst_rdata, burst_resp,
    input  line_rdata, line_resp,
    input  burst_read, burst_write, burst_address, burst_wdata
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Converts one cacheline read/write request into a BEATS-beat burst.
// Read beats are assembled into line_rdata slot by slot; write lines are
// latched on acceptance and presented one beat at a time.
module cacheline_burst_adaptor #(
  parameter int BEATS       = 4,
  parameter int BEAT_WIDTH  = 64,
  parameter int LINE_WIDTH  = 256,
  parameter int OFFSET_BITS = 5
) (
  input logic                      clk,
  input logic                      reset_n,
  cacheline_burst_adaptor_if.slave bus
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_next;
  logic [31:0]           r_addr;
  logic [LINE_WIDTH-1:0] r_wline;
  logic [LINE_WIDTH-1:0] r_rdata;
  logic                  w_beat_accept;
  logic                  w_last_beat;
  logic [31:0]           w_aligned_addr;
  logic                  w_unused_offset;

  // Offset bits are dropped on purpose: bursts always start on a line boundary.
  assign w_aligned_addr  = {bus.line_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign w_unused_offset = ^bus.line_address[OFFSET_BITS-1:0];

  // A beat only counts while a burst is in flight; stray resps elsewhere are ignored.
  assign w_beat_accept = bus.burst_resp && ((r_state == S_READ) || (r_state == S_WRITE));
  assign w_last_beat   = (r_count == CNT_W'(BEATS - 1));

  // State and beat counter register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Next-state and next-count decode; write wins over read when both are requested.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    unique case (r_state)
      S_IDLE: begin
        if (bus.line_write) begin
          w_state_next = S_WRITE;
          w_count_next = '0;
        end else if (bus.line_read) begin
          w_state_next = S_READ;
          w_count_next = '0;
        end
      end
      S_READ, S_WRITE: begin
        if (w_beat_accept) begin
          if (w_last_beat) begin
            w_state_next = S_DONE;
            w_count_next = '0;
          end else begin
            w_count_next = r_count + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  // Request capture on acceptance and read-beat assembly into the line.
  // NOTE: the line registers are plain flops, not a RAM, so they can and do take the async reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wline <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (bus.line_write) begin
          r_addr  <= w_aligned_addr;
          r_wline <= bus.line_wdata;
        end else if (bus.line_read) begin
          r_addr  <= w_aligned_addr;
        end
      end
      if ((r_state == S_READ) && w_beat_accept) begin
        r_rdata[r_count*BEAT_WIDTH +: BEAT_WIDTH] <= bus.burst_rdata;
      end
    end
  end

  assign bus.burst_read    = (r_state == S_READ);
  assign bus.burst_write   = (r_state == S_WRITE);
  assign bus.line_resp     = (r_state == S_DONE);
  assign bus.burst_address = r_addr;
  assign bus.burst_wdata   = r_wline[r_count*BEAT_WIDTH +: BEAT_WIDTH];
  assign bus.line_rdata    = r_rdata;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Randomized self-checking bench for cacheline_burst_adaptor. A transaction-
// level model tracks beats, the expected line and the expected response
// timing; inputs change on the falling edge and outputs are sampled there.
module tb_cacheline_burst_adaptor;

  localparam int BW = 64;
  localparam int LW = 256;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cacheline_burst_adaptor_if #(.BEAT_WIDTH(BW), .LINE_WIDTH(LW)) bus ();

  cacheline_burst_adaptor #(
    .BEATS(NB), .BEAT_WIDTH(BW), .LINE_WIDTH(LW), .OFFSET_BITS(5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [LW-1:0] exp_rdata = '0;

  task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // One complete line transaction. mask bit c gives burst_resp in cycle c
  // (cycle 0 = request cycle); mask==0 means random resp. exp_lat<=0 skips
  // the latency check. fixed_data drives beat n as a repeated digit n+1.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [LW-1:0] wline, input logic [31:0] mask,
                         input int exp_lat, input bit fixed_data);
    bit            is_wr    = wr;
    logic [31:0]   exp_addr = {addr[31:5], 5'b0};
    logic [LW-1:0] rline    = exp_rdata;
    int            beats    = 0;
    int            cyc      = 0;
    bit            done     = 1'b0;
    bit            r;
    logic [3:0]    dig;
    @(negedge clk);
    bus.line_read    = rd;
    bus.line_write   = wr;
    bus.line_address = addr;
    bus.line_wdata   = wline;
    bus.burst_resp   = 1'($urandom_range(0, 1));  // stray resp in IDLE
    bus.burst_rdata  = {$urandom, $urandom};
    while (!done) begin
      @(negedge clk);
      cyc++;
      // Scrambling the request fields must not disturb the accepted burst.
      bus.line_address = $urandom;
      bus.line_wdata   = {8{$urandom}};
      if (cyc > 100) begin
        check("timeout", LW'(cyc), LW'(0));
        done = 1'b1;
      end else if (beats == NB) begin
        check("line_resp_pulse", LW'(bus.line_resp), LW'(1));
        check("done_burst_read", LW'(bus.burst_read), LW'(0));
        check("done_burst_write", LW'(bus.burst_write), LW'(0));
        if (!is_wr) exp_rdata = rline;
        check("line_rdata", bus.line_rdata, exp_rdata);
        if (exp_lat > 0) check("latency", LW'(cyc), LW'(exp_lat));
        bus.burst_resp = 1'($urandom_range(0, 1));  // stray resp in DONE
        done = 1'b1;
      end else begin
        check("line_resp_low", LW'(bus.line_resp), LW'(0));
        check("burst_read", LW'(bus.burst_read), LW'(!is_wr));
        check("burst_write", LW'(bus.burst_write), LW'(is_wr));
        check("burst_address", LW'(bus.burst_address), LW'(exp_addr));
        if (is_wr) check("burst_wdata", LW'(bus.burst_wdata), LW'(wline[beats*BW +: BW]));
        r = (mask != 0) ? ((cyc < 32) ? mask[cyc] : 1'b1) : 1'($urandom_range(0, 1));
        bus.burst_resp = r;
        if (fixed_data) begin
          dig = 4'(beats + 1);
          bus.burst_rdata = {16{dig}};
        end else begin
          bus.burst_rdata = {$urandom, $urandom};
        end
        if (r) begin
          if (!is_wr) rline[beats*BW +: BW] = bus.burst_rdata;
          beats++;
        end
      end
    end
    // IDLE cycle: requester still holds its request, drops it now.
    @(negedge clk);
    check("idle_line_resp", LW'(bus.line_resp), LW'(0));
    check("idle_burst_read", LW'(bus.burst_read), LW'(0));
    check("idle_burst_write", LW'(bus.burst_write), LW'(0));
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
    bus.burst_resp = 1'($urandom_range(0, 1));
    // No spurious transaction from the held request.
    @(negedge clk);
    check("no_spurious_read", LW'(bus.burst_read), LW'(0));
    check("no_spurious_write", LW'(bus.burst_write), LW'(0));
    check("rdata_hold", bus.line_rdata, exp_rdata);
    bus.burst_resp = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_line_resp"}, LW'(bus.line_resp), LW'(0));
    check({tag, "_burst_read"}, LW'(bus.burst_read), LW'(0));
    check({tag, "_burst_write"}, LW'(bus.burst_write), LW'(0));
    check({tag, "_burst_address"}, LW'(bus.burst_address), LW'(0));
    check({tag, "_burst_wdata"}, LW'(bus.burst_wdata), LW'(0));
    check({tag, "_line_rdata"}, bus.line_rdata, LW'(0));
  endtask

  initial begin
    logic [LW-1:0] wl;
    bit            rd;
    bit            wr;
    reset_n          = 1'b0;
    bus.line_read    = 1'b0;
    bus.line_write   = 1'b0;
    bus.line_address = '0;
    bus.line_wdata   = '0;
    bus.burst_rdata  = '0;
    bus.burst_resp   = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Read with no gaps: line_resp 5 cycles after request, fixed beat data.
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 32'hFFFF_FFFE, 5, 1'b1);
    check("read_line_pattern", bus.line_rdata,
          {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

    // Write with resp on cycles 2, 5, 6 and 9.
    wl = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    run_txn(1'b0, 1'b1, 32'h8000_00FF, wl, 32'h0000_0264, 10, 1'b0);

    // Read and write together: write wins, line_rdata untouched.
    run_txn(1'b1, 1'b1, $urandom, {8{$urandom}}, 32'h0, -1, 1'b0);

    // Random mix, back-to-back, random gaps and stray responses.
    for (int i = 0; i < 12; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = !rd || (1'($urandom_range(0, 3) == 0));
      run_txn(rd, wr, $urandom, {8{$urandom}}, 32'h0, -1, 1'b0);
    end

    // Write last so the write-line register is nonzero, then reset mid-read.
    run_txn(1'b0, 1'b1, $urandom, {8{$urandom}}, 32'hFFFF_FFFE, 5, 1'b0);
    @(negedge clk);
    bus.line_read    = 1'b1;
    bus.line_address = 32'hCAFE_BEEF;
    @(negedge clk);
    bus.burst_resp   = 1'b1;
    bus.burst_rdata  = {$urandom, $urandom};
    @(negedge clk);
    bus.burst_rdata  = {$urandom, $urandom};
    @(negedge clk);
    bus.burst_resp   = 1'b0;
    check("pre_reset_burst_read", LW'(bus.burst_read), LW'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_rdata = '0;
    bus.line_read = 1'b0;
    @(negedge clk);
    check_all_zero("reset_hold");
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", LW'(bus.burst_read), LW'(0));
    run_txn(1'b1, 1'b0, $urandom, '0, 32'hFFFF_FFFE, 5, 1'b0);
    run_txn(1'b1, 1'b0, $urandom, '0, 32'h0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
